// File: rtl/ks_pkg.sv
// Shared Kogge-Stone types and helpers, reused by the prefix adders and subtractors.
package ks_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of radix-2 prefix levels for a power-of-two width.
  function automatic int unsigned ks_levels(input int unsigned width);
    return 32'($clog2(width));
  endfunction

  // Prefix operator: the higher group absorbs the lower one.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone level: combine each position with the one SPAN below it.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SPAN  = 1
) (
  input  gp_t [WIDTH-1:0] gp_in,
  output gp_t [WIDTH-1:0] gp_out
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    if (i >= int'(SPAN)) begin : g_comb
      assign gp_out[i] = gp_combine(gp_in[i], gp_in[i-int'(SPAN)]);
    end else begin : g_buf
      assign gp_out[i] = gp_in[i];
    end
  end

endmodule

// File: rtl/kogg_stone_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor d = a + ~b + 1 with valid/ready handshake.
// Optional KS_SUB_SAT_EN: unsigned saturation to zero on borrow.
module kogg_stone_sub_pipe
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SPLIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned LEVELS = ks_levels(WIDTH);
  localparam int unsigned POST   = LEVELS - SPLIT;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Carry-in of 1 is folded into bit 0: with cin=1 the bit-0 carry is just its propagate.
  logic [WIDTH-1:0] nb;
  gp_t  [WIDTH-1:0] gp_in;
  assign nb = ~b;

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      gp_in[i].g = a[i] & nb[i];
      gp_in[i].p = a[i] | nb[i];
    end
    gp_in[0].g = a[0] | nb[0];
  end

  // Stage S0: operand capture.
  logic             v0, msb0;
  logic [WIDTH-1:0] h0;
  gp_t  [WIDTH-1:0] gp0;

  always_ff @(posedge clk) begin
    if (!reset) v0 <= 1'b0;
    else if (en) v0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      h0   <= a ^ nb;
      gp0  <= gp_in;
      msb0 <= a[WIDTH-1];
    end
  end

  // Prefix levels ahead of the mid-pipe register.
  gp_t [WIDTH-1:0] pre [SPLIT+1];
  assign pre[0] = gp0;

  for (genvar l = 0; l < int'(SPLIT); l++) begin : g_pre
    ks_prefix_level #(.WIDTH(WIDTH), .SPAN(32'(1) << l)) u_lvl (
      .gp_in (pre[l]),
      .gp_out(pre[l+1])
    );
  end

  // Stage S1: partial prefix register.
  logic             v1, msb1;
  logic [WIDTH-1:0] h1;
  gp_t  [WIDTH-1:0] gp1;

  always_ff @(posedge clk) begin
    if (!reset) v1 <= 1'b0;
    else if (en) v1 <= v0;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      h1   <= h0;
      gp1  <= pre[SPLIT];
      msb1 <= msb0;
    end
  end

  // Prefix levels after the mid-pipe register.
  gp_t [WIDTH-1:0] post [POST+1];
  assign post[0] = gp1;

  for (genvar l = 0; l < int'(POST); l++) begin : g_post
    ks_prefix_level #(.WIDTH(WIDTH), .SPAN(32'(1) << (l + int'(SPLIT)))) u_lvl (
      .gp_in (post[l]),
      .gp_out(post[l+1])
    );
  end

  logic [WIDTH-1:0] carry, d_raw, d_next;
  logic             borrow_raw, ovf_raw, zero_next;

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) carry[i] = post[POST][i].g;
  end

  assign d_raw      = h1 ^ {carry[WIDTH-2:0], 1'b1};
  assign borrow_raw = ~carry[WIDTH-1];
  // h MSB is 0 exactly when the operand sign bits differ.
  assign ovf_raw    = !h1[WIDTH-1] && (d_raw[WIDTH-1] != msb1);

`ifdef KS_SUB_SAT_EN
  assign d_next    = borrow_raw ? '0 : d_raw;
  assign zero_next = borrow_raw || (d_raw == '0);
`else
  assign d_next    = d_raw;
  assign zero_next = (d_raw == '0);
`endif

  // Stage S2: result register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      d         <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= v1;
      d         <= d_next;
      borrow    <= borrow_raw;
      ovf       <= ovf_raw;
      zero      <= zero_next;
    end
  end

endmodule
